bus_arb_mux: RTL and testbench



---
 rtl/bus_arb_mux.sv | 136 +++++++++++++
 tb/tb_bus_arb_mux.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bus_arb_mux.sv
// N-master round-robin bus arbiter with an optional hold limit, followed by a
// registered AND-OR multiplexer that puts the granted master's command on the bus.
module bus_arb_mux #(
   parameter int N_REQ    = 2,
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    m_req,
   input  logic [N_REQ-1:0]    m_we,
   input  logic [N_REQ*AW-1:0] m_addr,
   input  logic [N_REQ*DW-1:0] m_wdata,
   output logic [N_REQ-1:0]    m_grant,
   output logic                s_sel,
   output logic                s_we,
   output logic [AW-1:0]       s_addr,
   output logic [DW-1:0]       s_wdata
);

   localparam int IW = $clog2(N_REQ);
   localparam int HW = $clog2(MAX_HOLD + 2);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state_reg;
   logic [IW-1:0]      last_reg;
   logic [HW-1:0]      hold_cnt_reg;

   logic               rr_found;
   logic [IW-1:0]      rr_winner;
   logic [N_REQ-1:0]   rr_onehot;
   logic               owner_req;
   logic               others_req;
   logic               hold_expired;

   // Offsets are scanned from farthest to nearest so the nearest requester after
   // last_reg overwrites the rest; the owner itself sits at offset N_REQ (lowest priority).
   always_comb begin
      rr_found  = 1'b0;
      rr_winner = last_reg;
      for (int k = N_REQ; k >= 1; k--) begin
         if (m_req[(int'(last_reg) + k) % N_REQ]) begin
            rr_found  = 1'b1;
            rr_winner = IW'((int'(last_reg) + k) % N_REQ);
         end
      end
   end

   assign rr_onehot    = {{(N_REQ-1){1'b0}}, 1'b1} << rr_winner;
   assign owner_req    = m_req[last_reg];
   assign others_req   = |(m_req & ~m_grant);
   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_reg == HW'(MAX_HOLD));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         m_grant      <= '0;
         last_reg     <= IW'(N_REQ - 1);
         hold_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|m_req) begin
                  m_grant      <= rr_onehot;
                  last_reg     <= rr_winner;
                  hold_cnt_reg <= HW'(1);
                  state_reg    <= GRANT;
               end
            end
            GRANT: begin
               if (!owner_req) begin
                  if (rr_found) begin
                     m_grant      <= rr_onehot;
                     last_reg     <= rr_winner;
                     hold_cnt_reg <= HW'(1);
                  end else begin
                     m_grant      <= '0;
                     hold_cnt_reg <= '0;
                     state_reg    <= IDLE;
                  end
               end else if (hold_expired && others_req) begin
                  // Owner is still at offset N_REQ, so rr_winner is another master here.
                  m_grant      <= rr_onehot;
                  last_reg     <= rr_winner;
                  hold_cnt_reg <= HW'(1);
               end else if (MAX_HOLD != 0 && !hold_expired) begin
                  hold_cnt_reg <= hold_cnt_reg + HW'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               m_grant   <= '0;
            end
         endcase
      end
   end

   logic [AW-1:0] addr_masked  [N_REQ];
   logic [DW-1:0] wdata_masked [N_REQ];
   logic [AW-1:0] addr_sel;
   logic [DW-1:0] wdata_sel;

   // Masking with the grant forces the bus fields to zero when nobody owns it.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
         assign addr_masked[gi]  = m_addr[gi*AW +: AW]  & {AW{m_grant[gi]}};
         assign wdata_masked[gi] = m_wdata[gi*DW +: DW] & {DW{m_grant[gi]}};
      end
   endgenerate

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         addr_sel  = addr_sel | addr_masked[i];
         wdata_sel = wdata_sel | wdata_masked[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_sel   <= 1'b0;
         s_we    <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
      end else begin
         s_sel   <= |m_grant;
         s_we    <= |(m_grant & m_we);
         s_addr  <= addr_sel;
         s_wdata <= wdata_sel;
      end
   end

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench: a 2-master instance driven by a vector table, plus a 4-master
// instance exercising round-robin wrap with a hold limit of one.
module tb_bus_arb_mux;

   logic        clk = 1'b0;
   logic        reset;

   logic [1:0]  m_req;
   logic [1:0]  m_we;
   logic [15:0] m_addr;
   logic [15:0] m_wdata;
   logic [1:0]  m_grant;
   logic        s_sel, s_we;
   logic [7:0]  s_addr, s_wdata;

   logic [3:0]  req4;
   logic [3:0]  we4;
   logic [31:0] addr4, wdata4;
   logic [3:0]  grant4;
   logic        sel4, swe4;
   logic [7:0]  saddr4, swdata4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bus_arb_mux #(.N_REQ(2), .AW(8), .DW(8), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_grant(m_grant), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata)
   );

   bus_arb_mux #(.N_REQ(4), .AW(8), .DW(8), .MAX_HOLD(1)) dut4 (
      .clk(clk), .reset(reset),
      .m_req(req4), .m_we(we4), .m_addr(addr4), .m_wdata(wdata4),
      .m_grant(grant4), .s_sel(sel4), .s_we(swe4), .s_addr(saddr4), .s_wdata(swdata4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic [7:0] a0;
      logic [1:0] g;
      logic       sel;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wd;
   } vec_t;

   vec_t vecs[22];

   initial begin
      // Columns: reset, m_req, master0 addr | expected after the edge: grant, sel, we, addr, wdata
      vecs[0]  = '{1'b1, 2'b11, 8'h3C, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00}; // reset
      vecs[1]  = '{1'b1, 2'b11, 8'h3C, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[2]  = '{1'b0, 2'b01, 8'h3C, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00}; // single request
      vecs[3]  = '{1'b0, 2'b01, 8'h3C, 2'b01, 1'b1, 1'b1, 8'h3C, 8'h11};
      vecs[4]  = '{1'b0, 2'b00, 8'h3C, 2'b00, 1'b1, 1'b1, 8'h3C, 8'h11}; // release to idle
      vecs[5]  = '{1'b0, 2'b00, 8'h3C, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[6]  = '{1'b1, 2'b00, 8'h3C, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00}; // contention from reset
      vecs[7]  = '{1'b0, 2'b11, 8'h3C, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[8]  = '{1'b0, 2'b11, 8'h3C, 2'b01, 1'b1, 1'b1, 8'h3C, 8'h11};
      vecs[9]  = '{1'b0, 2'b11, 8'h5A, 2'b01, 1'b1, 1'b1, 8'h5A, 8'h11}; // live address follow
      vecs[10] = '{1'b0, 2'b11, 8'h3C, 2'b01, 1'b1, 1'b1, 8'h3C, 8'h11};
      vecs[11] = '{1'b0, 2'b11, 8'h3C, 2'b10, 1'b1, 1'b1, 8'h3C, 8'h11}; // preempt
      vecs[12] = '{1'b0, 2'b11, 8'h3C, 2'b10, 1'b1, 1'b0, 8'hA5, 8'h22};
      vecs[13] = '{1'b0, 2'b11, 8'h3C, 2'b10, 1'b1, 1'b0, 8'hA5, 8'h22};
      vecs[14] = '{1'b0, 2'b11, 8'h3C, 2'b10, 1'b1, 1'b0, 8'hA5, 8'h22};
      vecs[15] = '{1'b0, 2'b11, 8'h3C, 2'b01, 1'b1, 1'b0, 8'hA5, 8'h22};
      vecs[16] = '{1'b0, 2'b11, 8'h3C, 2'b01, 1'b1, 1'b1, 8'h3C, 8'h11};
      vecs[17] = '{1'b0, 2'b10, 8'h3C, 2'b10, 1'b1, 1'b1, 8'h3C, 8'h11}; // handover
      vecs[18] = '{1'b0, 2'b10, 8'h3C, 2'b10, 1'b1, 1'b0, 8'hA5, 8'h22};
      vecs[19] = '{1'b1, 2'b11, 8'h3C, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00}; // reset mid-grant
      vecs[20] = '{1'b0, 2'b11, 8'h3C, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[21] = '{1'b0, 2'b11, 8'h3C, 2'b01, 1'b1, 1'b1, 8'h3C, 8'h11};

      reset   = 1'b1;
      m_req   = 2'b00;
      m_we    = 2'b01;
      m_addr  = {8'hA5, 8'h3C};
      m_wdata = {8'h22, 8'h11};
      req4    = 4'b0000;
      we4     = 4'b0000;
      addr4   = {8'h43, 8'h42, 8'h41, 8'h40};
      wdata4  = 32'h0;

      for (int v = 0; v < 22; v++) begin
         @(negedge clk);
         reset       = vecs[v].rst;
         m_req       = vecs[v].req;
         m_addr[7:0] = vecs[v].a0;
         @(posedge clk);
         #1;
         $display("vec %0d: rst=%0b req=%b grant=%b sel=%0b we=%0b addr=%h wdata=%h",
                  v, vecs[v].rst, vecs[v].req, m_grant, s_sel, s_we, s_addr, s_wdata);
         check($sformatf("v%0d grant", v), 32'(m_grant), 32'(vecs[v].g));
         check($sformatf("v%0d s_sel", v), 32'(s_sel),   32'(vecs[v].sel));
         check($sformatf("v%0d s_we", v),  32'(s_we),    32'(vecs[v].we));
         check($sformatf("v%0d s_addr", v), 32'(s_addr), 32'(vecs[v].addr));
         check($sformatf("v%0d s_wdata", v), 32'(s_wdata), 32'(vecs[v].wd));
      end

      // Four-master wrap: park the pointer on master 2, then hold 1011.
      @(negedge clk);
      m_req = 2'b00;
      req4  = 4'b0100;
      @(posedge clk);
      #1;
      $display("rr4 setup: req=%b grant=%b", req4, grant4);
      check("rr4 setup grant", 32'(grant4), 32'h4);

      begin
         logic [3:0] exp_g [5];
         exp_g[0] = 4'b1000;
         exp_g[1] = 4'b0001;
         exp_g[2] = 4'b0010;
         exp_g[3] = 4'b1000;
         exp_g[4] = 4'b0001;
         for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            req4 = 4'b1011;
            @(posedge clk);
            #1;
            $display("rr4 step %0d: req=%b grant=%b sel=%0b addr=%h", s, req4, grant4, sel4, saddr4);
            check($sformatf("rr4 step%0d grant", s), 32'(grant4), 32'(exp_g[s]));
            if (s > 0)
               check($sformatf("rr4 step%0d s_addr", s), 32'(saddr4),
                     32'(8'h40 + 8'(s == 1 ? 3 : (s == 2 ? 0 : (s == 3 ? 1 : 3)))));
            check($sformatf("rr4 step%0d s_sel", s), 32'(sel4), 32'h1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
